// File: rtl/dsp_seq_pkg.sv
// dsp_seq_pkg: shared state encoding and defaults for the DSP frame sequencer.
package dsp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLDOFF = 2'd2,
    DONE    = 2'd3
  } seq_state_e;

  localparam int unsigned DEFAULT_FRAME_LEN = 1024;

  // A programmed frame length of 0 behaves as a one-sample frame.
  function automatic int unsigned eff_len(input int unsigned len);
    return (len == 0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/dsp_seq_stall_wdt.sv
// dsp_seq_stall_wdt: counts consecutive downstream-stall cycles while capturing
// and emits a one-cycle pulse each time LIMIT stalls in a row are reached.
// The count restarts after every pulse, so a permanent stall pulses every LIMIT cycles.
module dsp_seq_stall_wdt #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic active,
  input  logic stall,
  output logic irq
);

  localparam int unsigned CNTW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CNTW-1:0] cnt_q;
  logic            irq_q;

  // Consecutive-stall counter; any non-stall or inactive cycle clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else if (ce) begin
      irq_q <= 1'b0;
      if (active && stall) begin
        if (cnt_q == CNTW'(LIMIT - 1)) begin
          cnt_q <= '0;
          irq_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNTW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign irq = irq_q;

endmodule

// File: rtl/dsp_frame_sequencer.sv
// dsp_frame_sequencer: cuts the decimated sample stream into fixed-length
// frames for the FFT window, drops samples between frames (holdoff), drives
// tlast and raises per-frame / stall interrupts.
// Optional stall watchdog: define DSP_FRAME_SEQ_STALL_WDT_EN to enable it;
// without it irq_stall is tied low.
//
// Handshake: a beat moves on any cycle where valid and ready are both high.
// In CAPTURE the block is a zero-latency wire (tready_s follows tready_m,
// tvalid_m follows tvalid_s); outside CAPTURE input is always accepted and
// dropped, and tvalid_m stays low. ce=0 forces both ready and valid low.
module dsp_frame_sequencer #(
  parameter int DW          = 16,
  parameter int LW          = 12,
  parameter int HW          = 16,
  parameter int CW          = 16,
  parameter int STALL_LIMIT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic [DW-1:0] tdata_s,
  input  logic          tvalid_s,
  output logic          tready_s,
  output logic [DW-1:0] tdata_m,
  output logic          tvalid_m,
  input  logic          tready_m,
  output logic          tlast_m,
  input  logic          start,
  input  logic          abort,
  input  logic          continuous,
  input  logic [LW-1:0] frame_len,
  input  logic [HW-1:0] holdoff,
  output logic          busy,
  output logic [CW-1:0] frame_cnt,
  output logic          irq_frame,
  output logic          irq_stall,
  output logic [1:0]    state_dbg
);

  import dsp_seq_pkg::*;

  seq_state_e    state_q, state_nx;
  logic [LW-1:0] len_q, cnt_q, len_eff;
  logic [HW-1:0] hold_q, hcnt_q;
  logic [CW-1:0] frame_cnt_q;
  logic          irq_frame_q;
  logic          run, xfer, last_xfer, drop, hold_end, frame_done, enter_capture;

  assign run        = ce && !reset;
  assign len_eff    = LW'(eff_len(32'(frame_len)));
  assign xfer       = (state_q == CAPTURE) && tvalid_s && tready_m;
  assign last_xfer  = xfer && (cnt_q == len_q - LW'(1));
  assign drop       = (state_q == HOLDOFF) && tvalid_s;
  assign hold_end   = drop && (hcnt_q == hold_q - HW'(1));
  assign frame_done = last_xfer && !abort;
  // Shadow length/holdoff are reloaded on every entry into CAPTURE.
  assign enter_capture = !abort &&
                         (((state_q == IDLE) && start) ||
                          (last_xfer && continuous && (hold_q == '0)) ||
                          hold_end);

  // Next-state decode and stream-side outputs.
  always_comb begin
    state_nx = state_q;
    tready_s = 1'b0;
    tvalid_m = 1'b0;
    tlast_m  = 1'b0;
    tdata_m  = tdata_s;
    case (state_q)
      IDLE: begin
        tready_s = run;
        if (start) state_nx = CAPTURE;
      end
      CAPTURE: begin
        tready_s = run && tready_m;
        tvalid_m = run && tvalid_s;
        tlast_m  = run && (cnt_q == len_q - LW'(1));
        if (last_xfer) begin
          if (!continuous)        state_nx = DONE;
          else if (hold_q == '0)  state_nx = CAPTURE;
          else                    state_nx = HOLDOFF;
        end
      end
      HOLDOFF: begin
        tready_s = run;
        if (hold_end) state_nx = CAPTURE;
      end
      DONE: begin
        tready_s = run;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  // State, shadow registers, sample/holdoff counters and frame status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= LW'(DEFAULT_FRAME_LEN);
      hold_q      <= '0;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      frame_cnt_q <= '0;
      irq_frame_q <= 1'b0;
    end else if (ce) begin
      state_q     <= state_nx;
      irq_frame_q <= frame_done;
      if (frame_done) frame_cnt_q <= frame_cnt_q + CW'(1);
      if (abort) begin
        cnt_q  <= '0;
        hcnt_q <= '0;
      end else if (enter_capture) begin
        len_q  <= len_eff;
        hold_q <= holdoff;
        cnt_q  <= '0;
        hcnt_q <= '0;
      end else if (last_xfer) begin
        cnt_q  <= '0;
        hcnt_q <= '0;
      end else if (xfer) begin
        cnt_q  <= cnt_q + LW'(1);
      end else if (drop) begin
        hcnt_q <= hcnt_q + HW'(1);
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign frame_cnt = frame_cnt_q;
  assign irq_frame = run && irq_frame_q;
  assign state_dbg = state_q;

`ifdef DSP_FRAME_SEQ_STALL_WDT_EN
  logic stall_pulse;

  dsp_seq_stall_wdt #(.LIMIT(STALL_LIMIT)) u_stall_wdt (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .active ((state_q == CAPTURE) && !abort),
    .stall  (tvalid_s && !tready_m),
    .irq    (stall_pulse)
  );

  assign irq_stall = run && stall_pulse;
`else
  logic unused_stall_cfg;
  assign unused_stall_cfg = ^STALL_LIMIT;
  assign irq_stall = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_frame_sequencer.sv
// tb_dsp_frame_sequencer: directed scenarios plus randomized traffic, checked
// against a sample-position reference model of the framing rules.
module tb_dsp_frame_sequencer;

  localparam int DW          = 16;
  localparam int LW          = 12;
  localparam int HW          = 16;
  localparam int CW          = 16;
  localparam int STALL_LIMIT = 64;

  logic          clk;
  logic          reset, ce;
  logic [DW-1:0] tdata_s, tdata_m;
  logic          tvalid_s, tready_s, tvalid_m, tready_m, tlast_m;
  logic          start, abort, continuous;
  logic [LW-1:0] frame_len;
  logic [HW-1:0] holdoff;
  logic          busy, irq_frame, irq_stall;
  logic [CW-1:0] frame_cnt;
  logic [1:0]    state_dbg;

  dsp_frame_sequencer #(
    .DW(DW), .LW(LW), .HW(HW), .CW(CW), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .tdata_s(tdata_s), .tvalid_s(tvalid_s), .tready_s(tready_s),
    .tdata_m(tdata_m), .tvalid_m(tvalid_m), .tready_m(tready_m), .tlast_m(tlast_m),
    .start(start), .abort(abort), .continuous(continuous),
    .frame_len(frame_len), .holdoff(holdoff),
    .busy(busy), .frame_cnt(frame_cnt), .irq_frame(irq_frame), .irq_stall(irq_stall),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / monitor state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] last_q[$];
  int irq_f_seen, irq_s_seen;
  int ramp;

  // ---------------- reference model ----------------
  // m_k is the position of the next input sample inside the current
  // frame+holdoff period; positions below m_len belong to the frame.
  bit            m_active, m_done, m_irq_f, m_irq_s;
  int            m_k, m_len, m_hold, m_stall_run;
  logic [CW-1:0] m_frames;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_latch();
    m_len  = (frame_len == 0) ? 1 : int'(frame_len);
    m_hold = int'(holdoff);
  endtask

  task automatic check_outputs();
    bit run, in_frame;
    run      = ce;
    in_frame = m_active && (m_k < m_len);
    chk("tready_s",  tready_s,  run && (in_frame ? tready_m : 1'b1));
    chk("tvalid_m",  tvalid_m,  run && in_frame && tvalid_s);
    chk("tlast_m",   tlast_m,   run && in_frame && (m_k == m_len - 1));
    chk("busy",      busy,      m_active || m_done);
    chk("frame_cnt", frame_cnt, m_frames);
    chk("irq_frame", irq_frame, run && m_irq_f);
`ifdef DSP_FRAME_SEQ_STALL_WDT_EN
    chk("irq_stall", irq_stall, run && m_irq_s);
`else
    chk("irq_stall", irq_stall, 1'b0);
`endif
    if (run && in_frame && tvalid_s && tready_m) exp_q.push_back(tdata_s);
    if (tvalid_m && tready_m) begin
      got_q.push_back(tdata_m);
      if (tlast_m) last_q.push_back(tdata_m);
      if (exp_q.size() == 0) chk("sb_extra_beat", 32'(exp_q.size()), 32'd1);
      else chk("sb_data", tdata_m, exp_q.pop_front());
    end
    if (irq_frame) irq_f_seen++;
    if (irq_stall) irq_s_seen++;
  endtask

  task automatic model_update();
    bit nf, ns, stalling;
    if (!ce) return;
    nf = 0;
    ns = 0;
    stalling = !abort && m_active && (m_k < m_len) && tvalid_s && !tready_m;
    if (stalling) begin
      m_stall_run++;
      if (m_stall_run == STALL_LIMIT) begin
        ns = 1;
        m_stall_run = 0;
      end
    end else begin
      m_stall_run = 0;
    end
    if (abort) begin
      m_active = 0;
      m_done   = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1;
        m_k      = 0;
        model_latch();
      end
    end else if (m_k < m_len) begin
      if (tvalid_s && tready_m) begin
        m_k++;
        if (m_k == m_len) begin
          nf = 1;
          m_frames++;
          if (!continuous) begin
            m_active = 0;
            m_done   = 1;
          end else if (m_hold == 0) begin
            m_k = 0;
            model_latch();
          end
        end
      end
    end else if (tvalid_s) begin
      m_k++;
      if (m_k == m_len + m_hold) begin
        m_k = 0;
        model_latch();
      end
    end
    m_irq_f = nf;
    m_irq_s = ns;
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1 with inputs set; checks at negedge, returns at next posedge+1.
  task automatic cycle();
    bit acc;
    @(negedge clk);
    check_outputs();
    acc = tvalid_s && tready_s;
    model_update();
    @(posedge clk);
    #1;
    if (acc) ramp++;
    tdata_s = DW'(ramp);
  endtask

  task automatic clear_mon();
    got_q.delete();
    last_q.delete();
    irq_f_seen = 0;
    irq_s_seen = 0;
    ramp       = 0;
    tdata_s    = '0;
  endtask

  // Abort whatever is running, then start a new capture; no samples offered.
  task automatic go();
    tvalid_s = 1'b0;
    abort = 1'b1; cycle(); abort = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; ce = 1'b1; tvalid_s = 1'b1; tready_m = 1'b1;
    start = 1'b0; abort = 1'b0; continuous = 1'b0;
    frame_len = LW'(8); holdoff = '0; tdata_s = '0; ramp = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_tvalid_m", tvalid_m, 1'b0);
      chk("rst_tready_s", tready_s, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_frame_cnt", frame_cnt, '0);
      chk("rst_irq", {irq_frame, irq_stall}, 2'b00);
      @(posedge clk);
      #1;
    end
    reset = 1'b0; tvalid_s = 1'b0;
    m_active = 0; m_done = 0; m_irq_f = 0; m_irq_s = 0;
    m_k = 0; m_len = 1; m_hold = 0; m_stall_run = 0; m_frames = '0;

    // Single frame of 8 out of a 0..15 ramp.
    frame_len = LW'(8); holdoff = '0; continuous = 1'b0; tready_m = 1'b1;
    clear_mon(); go();
    tvalid_s = 1'b1;
    for (int i = 0; i < 100 && ramp < 16; i++) cycle();
    tvalid_s = 1'b0;
    chk("sf_ramp_done", ramp, 16);
    chk("sf_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) chk("sf_data", got_q[i], i);
    chk("sf_tlast_n", last_q.size(), 1);
    if (last_q.size() > 0) chk("sf_tlast_val", last_q[0], 7);
    chk("sf_irq", irq_f_seen, 1);
    chk("sf_frame_cnt", frame_cnt, 1);
    chk("sf_busy", busy, 1'b0);

    // Continuous frames of 4 with holdoff 3.
    frame_len = LW'(4); holdoff = HW'(3); continuous = 1'b1;
    clear_mon(); go();
    tvalid_s = 1'b1;
    for (int i = 0; i < 100 && ramp < 21; i++) cycle();
    tvalid_s = 1'b0;
    chk("ct_ramp_done", ramp, 21);
    chk("ct_count", got_q.size(), 12);
    for (int f = 0; f < 3; f++)
      for (int j = 0; j < 4; j++)
        if (4 * f + j < got_q.size()) chk("ct_data", got_q[4 * f + j], 7 * f + j);
    chk("ct_tlast_n", last_q.size(), 3);
    for (int f = 0; f < 3 && f < last_q.size(); f++) chk("ct_tlast_val", last_q[f], 7 * f + 3);
    chk("ct_irq", irq_f_seen, 3);
    chk("ct_frame_cnt", frame_cnt, 4);

    // Backpressure: tready_m toggles every cycle.
    frame_len = LW'(4); holdoff = '0; continuous = 1'b0;
    clear_mon(); go();
    tvalid_s = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tready_m = (i % 2 == 0);
      cycle();
    end
    tvalid_s = 1'b0; tready_m = 1'b1;
    chk("bp_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("bp_data", got_q[i], i);
    chk("bp_tlast_n", last_q.size(), 1);
    if (last_q.size() > 0) chk("bp_tlast_val", last_q[0], 3);
    chk("bp_frame_cnt", frame_cnt, 5);

    // Abort after 2 of 8 samples, then restart.
    frame_len = LW'(8); continuous = 1'b0;
    clear_mon(); go();
    tvalid_s = 1'b1;
    repeat (2) cycle();
    tvalid_s = 1'b0;
    abort = 1'b1; cycle(); abort = 1'b0;
    cycle();
    chk("ab_busy", busy, 1'b0);
    chk("ab_count", got_q.size(), 2);
    chk("ab_tlast_n", last_q.size(), 0);
    chk("ab_irq", irq_f_seen, 0);
    got_q.delete(); last_q.delete();
    start = 1'b1; cycle(); start = 1'b0;
    tvalid_s = 1'b1;
    for (int i = 0; i < 50 && got_q.size() < 8; i++) cycle();
    tvalid_s = 1'b0;
    repeat (2) cycle();
    chk("ab2_count", got_q.size(), 8);
    if (got_q.size() > 0) chk("ab2_first", got_q[0], 2);
    chk("ab2_tlast_n", last_q.size(), 1);
    if (last_q.size() > 0) chk("ab2_tlast_val", last_q[0], 9);
    chk("ab2_frame_cnt", frame_cnt, 6);

    // Frame length 0 behaves as a single-sample frame.
    frame_len = '0; continuous = 1'b0;
    clear_mon(); go();
    tvalid_s = 1'b1;
    cycle();
    tvalid_s = 1'b0;
    repeat (2) cycle();
    chk("z_count", got_q.size(), 1);
    chk("z_tlast_n", last_q.size(), 1);
    chk("z_frame_cnt", frame_cnt, 7);

    // Sustained downstream stall for 130 cycles.
    frame_len = LW'(8); continuous = 1'b0;
    clear_mon(); go();
    tvalid_s = 1'b1; tready_m = 1'b0;
    repeat (130) cycle();
    tvalid_s = 1'b0; tready_m = 1'b1;
`ifdef DSP_FRAME_SEQ_STALL_WDT_EN
    chk("st_irq_count", irq_s_seen, 2);
`else
    chk("st_irq_count", irq_s_seen, 0);
`endif
    chk("st_busy", busy, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      ce       = ($urandom_range(0, 9) != 0);
      tvalid_s = ($urandom_range(0, 3) != 0);
      tready_m = ($urandom_range(0, 3) != 0);
      start    = ($urandom_range(0, 19) == 0);
      abort    = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 29) == 0) frame_len = LW'($urandom_range(0, 9));
      if ($urandom_range(0, 29) == 0) holdoff = HW'($urandom_range(0, 4));
      if ($urandom_range(0, 49) == 0) continuous = 1'($urandom_range(0, 1));
      cycle();
    end
    ce = 1'b1; start = 1'b0; tvalid_s = 1'b0; tready_m = 1'b1;
    abort = 1'b1; cycle(); abort = 1'b0;
    repeat (2) cycle();
    chk("sb_drained", exp_q.size(), 0);
    chk("end_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
